// File: rtl/cpu_pkg.sv
// cpu_pkg: shared address/instruction types and the fetch entry record
package cpu_pkg;
   typedef logic [15:0] addr_t;
   typedef logic [15:0] instr_t;
   localparam addr_t RESET_PC_DEFAULT = 16'h0000;
   typedef struct packed {
      instr_t instr;
      addr_t  pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: ROM and decode-side signals of the fetch stage
interface fetch_queue_if #(parameter int DEPTH = 4);
   import cpu_pkg::*;
   addr_t                    rom_address;
   instr_t                   rom_data;
   logic                     redirect_valid;
   addr_t                    redirect_pc;
   logic                     dec_ready;
   logic                     dec_valid;
   instr_t                   dec_instruction;
   addr_t                    dec_pc;
   logic [$clog2(DEPTH):0]   queue_count;
   modport master (
      output rom_address, dec_valid, dec_instruction, dec_pc, queue_count,
      input  rom_data, redirect_valid, redirect_pc, dec_ready
   );
   modport slave (
      input  rom_address, dec_valid, dec_instruction, dec_pc, queue_count,
      output rom_data, redirect_valid, redirect_pc, dec_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry queue of fetched instructions with flush; head holds last shown value when empty
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  fetch_entry_t           din_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output fetch_entry_t           head_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   fetch_entry_t   mem_q [DEPTH];
   fetch_entry_t   last_q;
   logic [AW-1:0]  wr_q, rd_q;
   logic [CW-1:0]  cnt_q;
   logic           do_push, do_pop;
   assign do_push = push_i & ~flush_i;
   assign do_pop  = pop_i & ~flush_i & (cnt_q != '0);
   assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : last_q;
   assign count_o = cnt_q;
   // entry storage; never read before written because head falls back to last_q when empty
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end
   // pointers and occupancy; flush empties the queue and drops any push of this cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         last_q <= '0;
      end else begin
         last_q <= head_o;
         if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
         end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
         end
      end
   end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: owns the PC, issues ROM reads under credit control and handles branch redirects
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int    DEPTH    = 4,
   parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   fetch_queue_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int KW = CW + 1;
   addr_t          fetch_pc_q, fetch_pc_d;
   addr_t          inflight_pc_q, inflight_pc_d;
   logic           inflight_q, inflight_d;
   logic           pop, issue, push, redirect;
   logic [KW-1:0]  credit;
   addr_t          rom_addr;
   fetch_entry_t   head, din;
   logic [CW-1:0]  count;
   assign redirect = bus.redirect_valid;
   assign push     = inflight_q & ~redirect;
   assign din      = '{instr: bus.rom_data, pc: inflight_pc_q};
   // issue credit counts queued plus in-flight entries so a returning read always has a free slot
   always_comb begin
      pop           = (count != '0) & bus.dec_ready & ~redirect;
      credit        = KW'(count) + KW'(inflight_q) - KW'(pop);
      issue         = redirect | (credit < KW'(DEPTH));
      rom_addr      = redirect ? bus.redirect_pc : fetch_pc_q;
      fetch_pc_d    = issue ? rom_addr + 16'd1 : fetch_pc_q;
      inflight_d    = issue;
      inflight_pc_d = issue ? rom_addr : inflight_pc_q;
   end
   // PC and in-flight read tracking
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end
   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .din_i   (din),
      .pop_i   (pop),
      .flush_i (redirect),
      .head_o  (head),
      .count_o (count)
   );
   assign bus.rom_address     = rom_addr;
   assign bus.dec_valid       = count != '0;
   assign bus.dec_instruction = head.instr;
   assign bus.dec_pc          = head.pc;
   assign bus.queue_count     = count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch latency, stall, redirect, PC wrap and async reset
module tb_fetch_queue;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   fetch_queue_if #(.DEPTH(4)) bus ();
   fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   // ROM contents: ROM[i] = 16'hA000 + i, one cycle read latency
   always @(posedge clk) bus.rom_data <= 16'hA000 + bus.rom_address;
   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic head(input string tag, input logic [15:0] pc, input logic [15:0] ins);
      check({tag, "_valid"}, 16'(bus.dec_valid), 16'd1);
      check({tag, "_pc"}, bus.dec_pc, pc);
      check({tag, "_instr"}, bus.dec_instruction, ins);
   endtask
   task automatic cyc(input logic rdy, input logic rv, input logic [15:0] rpc);
      @(posedge clk);
      #1;
      bus.dec_ready      = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      #1;
   endtask
   task automatic restart();
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.dec_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      #1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
   endtask
   initial begin
      reset = 1'b0;
      bus.dec_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 16'h0000;
      repeat (2) @(posedge clk);
      #2;
      check("rst_valid", 16'(bus.dec_valid), 16'd0);
      check("rst_instr", bus.dec_instruction, 16'h0000);
      check("rst_pc", bus.dec_pc, 16'h0000);
      check("rst_count", 16'(bus.queue_count), 16'd0);
      check("rst_rom", bus.rom_address, 16'h0000);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("a0_rom", bus.rom_address, 16'h0000);
      cyc(1, 0, 0);
      check("a1_valid", 16'(bus.dec_valid), 16'd0);
      check("a1_rom", bus.rom_address, 16'h0001);
      cyc(1, 0, 0);
      head("a2", 16'h0000, 16'hA000);
      cyc(1, 0, 0);
      head("a3", 16'h0001, 16'hA001);
      check("a3_count", 16'(bus.queue_count), 16'd1);
      cyc(1, 0, 0);
      head("a4", 16'h0002, 16'hA002);
      cyc(1, 0, 0);
      head("a5", 16'h0003, 16'hA003);
      restart();
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      head("b2", 16'h0000, 16'hA000);
      cyc(0, 0, 0);
      head("b3", 16'h0001, 16'hA001);
      check("b3_count", 16'(bus.queue_count), 16'd1);
      cyc(0, 0, 0);
      check("b4_count", 16'(bus.queue_count), 16'd2);
      check("b4_rom", bus.rom_address, 16'h0004);
      cyc(0, 0, 0);
      check("b5_count", 16'(bus.queue_count), 16'd3);
      check("b5_rom", bus.rom_address, 16'h0005);
      for (int i = 6; i <= 12; i++) begin
         cyc(0, 0, 0);
         check("stall_count", 16'(bus.queue_count), 16'd4);
         check("stall_rom", bus.rom_address, 16'h0005);
         head("stall", 16'h0001, 16'hA001);
      end
      for (int i = 1; i <= 5; i++) begin
         cyc(1, 0, 0);
         head("drain", 16'(i), 16'hA000 + 16'(i));
      end
      restart();
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      cyc(1, 1, 16'h0040);
      check("c5_count", 16'(bus.queue_count), 16'd3);
      check("c5_rom", bus.rom_address, 16'h0040);
      head("c5", 16'h0001, 16'hA001);
      cyc(1, 0, 0);
      check("c6_count", 16'(bus.queue_count), 16'd0);
      check("c6_valid", 16'(bus.dec_valid), 16'd0);
      check("c6_rom", bus.rom_address, 16'h0041);
      cyc(1, 0, 0);
      head("c7", 16'h0040, 16'hA040);
      cyc(1, 0, 0);
      head("c8", 16'h0041, 16'hA041);
      cyc(1, 1, 16'h0080);
      head("c9", 16'h0042, 16'hA042);
      check("c9_rom", bus.rom_address, 16'h0080);
      cyc(1, 1, 16'hFFFE);
      check("c10_count", 16'(bus.queue_count), 16'd0);
      check("c10_valid", 16'(bus.dec_valid), 16'd0);
      check("c10_rom", bus.rom_address, 16'hFFFE);
      cyc(1, 0, 0);
      check("c11_valid", 16'(bus.dec_valid), 16'd0);
      check("c11_rom", bus.rom_address, 16'hFFFF);
      cyc(1, 0, 0);
      head("c12", 16'hFFFE, 16'h9FFE);
      check("c12_rom", bus.rom_address, 16'h0000);
      cyc(1, 0, 0);
      head("c13", 16'hFFFF, 16'h9FFF);
      cyc(1, 0, 0);
      head("c14", 16'h0000, 16'hA000);
      cyc(1, 0, 0);
      head("c15", 16'h0001, 16'hA001);
      repeat (4) cyc(0, 0, 0);
      check("e_count", 16'(bus.queue_count), 16'd4);
      head("e", 16'h0002, 16'hA002);
      #1;
      reset = 1'b0;
      #1;
      check("e_rst_valid", 16'(bus.dec_valid), 16'd0);
      check("e_rst_instr", bus.dec_instruction, 16'h0000);
      check("e_rst_pc", bus.dec_pc, 16'h0000);
      check("e_rst_count", 16'(bus.queue_count), 16'd0);
      check("e_rst_rom", bus.rom_address, 16'h0000);
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.dec_ready = 1'b1;
      #1;
      check("f0_rom", bus.rom_address, 16'h0000);
      check("f0_valid", 16'(bus.dec_valid), 16'd0);
      cyc(1, 0, 0);
      check("f1_valid", 16'(bus.dec_valid), 16'd0);
      cyc(1, 0, 0);
      head("f2", 16'h0000, 16'hA000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage that owns the program counter and drives the synchronous instruction ROM (1-cycle read latency).
- Buffers returned instructions, each tagged with its PC, in a small FIFO and hands them to the Fetch-Decode register over a valid/ready handshake.
- Absorbs decode stalls without re-fetching.
- Accepts branch redirects from decode: flushes all buffered and in-flight fetches, then restarts at the target.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- rom_address  out  16  ROM read address, combinational from current state.
- rom_data  in  16  ROM output; valid the cycle after its address is issued.
- redirect_valid  in  1  branch taken in decode this cycle.
- redirect_pc  in  16  branch target.
- dec_ready  in  1  decode can accept this cycle (low = stall).
- dec_valid  out  1  head entry is valid.
- dec_instruction  out  16  head instruction.
- dec_pc  out  16  PC of head instruction.
- queue_count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (reset low, asynchronous):
  - fetch_pc = RESET_PC; queue empty; in-flight flag = 0.
  - Outputs: dec_valid = 0, dec_instruction = 0, dec_pc = 0, queue_count = 0, rom_address = RESET_PC.
- Pop: dec_valid & dec_ready & !redirect_valid. The head advances at the clock edge.
- Issue condition: (count + inflight - pop) < DEPTH. This is credit accounting, so overflow is impossible.
- On issue:
  - rom_address = fetch_pc.
  - fetch_pc <= fetch_pc + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
  - inflight <= 1; inflight_pc <= fetch_pc.
- No issue: rom_address holds fetch_pc; inflight <= 0.
- Return: if inflight = 1 at a cycle, rom_data plus inflight_pc are pushed at that cycle's closing edge.
- Push and pop in the same cycle are both honoured; count is unchanged.
- Redirect (redirect_valid = 1), highest priority:
  - Queue cleared and inflight data of this cycle discarded, even if a return is arriving.
  - dec_valid is still driven from the current head but no pop occurs.
  - rom_address = redirect_pc (combinational); issue redirect_pc this cycle.
  - inflight_pc <= redirect_pc; fetch_pc <= redirect_pc + 1.
  - Redirect to first valid target instruction = 2 cycles.
- Latency: address issued in cycle N, entry visible on dec_* in cycle N+2. After reset release, PC 0 appears at cycle 2.
- Throughput: 1 instruction/cycle sustained while dec_ready = 1.
- Stall: while dec_ready = 0, the head and dec_* outputs are held stable. Issue continues until count + inflight = DEPTH, then rom_address holds.
- Empty: dec_valid = 0; dec_instruction and dec_pc hold their last values.
- FIFO pointers are log2(DEPTH) bits and wrap naturally; count is one bit wider to distinguish full from empty.
- Back-to-back redirects: each one fully supersedes the prior one.
- Reset mid-operation: all state returns to reset values immediately; the first fetch after release is RESET_PC.

Decomposition:
- Shared package cpu_pkg holds:
  - typedefs: addr_t = logic[15:0], instr_t = logic[15:0].
  - constant RESET_PC default.
  - struct fetch_entry_t {instr_t instr; addr_t pc;}.
- Sub-module fetch_fifo: DEPTH-entry storage of fetch_entry_t with push, pop, flush and count.
- fetch_queue keeps the PC, issue credit and redirect logic.

Test Plan:
- Reset, dec_ready = 1, ROM[i] = 16'hA000+i -> dec_valid rises at cycle 2; dec_pc 0,1,2,3 with instructions A000..A003 on consecutive cycles.
- dec_ready = 0 from cycle 3 for 10 cycles, DEPTH = 4:
  - queue_count saturates at 4.
  - rom_address frozen.
  - dec_pc held at 1 throughout.
  - On release, PCs 1..5 delivered in order with no duplicates or gaps.
- redirect_valid with redirect_pc = 16'h0040 while 3 entries are queued and 1 is in flight:
  - next cycle queue_count = 0 and dec_valid = 0.
  - cycle after that, dec_pc = 16'h0040 with instruction ROM[0x40]; no stale PCs ever appear.
- Redirect on the same cycle as dec_ready = 1 and a valid head -> head not counted as consumed; next delivered PC is the target.
- redirect_pc = 16'hFFFE -> delivered PCs FFFE, FFFF, 0000, 0001.
- Assert reset low mid-stall with 4 entries queued -> outputs zero immediately; after release, PC 0 delivered at cycle 2.
